// File: rtl/lfsr_depad_engine_if.sv
// Engine <-> system bundle: Start/Ack handshake, data-memory port and run status.
// Engine takes the master side; the memory/host takes the slave side.
// Read data is combinational from mem_addr; writes land at mem_wr_addr on the rising edge.
interface lfsr_depad_engine_if #(
   parameter int LW = 7
);
   logic          Start;
   logic          Ack;
   logic [7:0]    mem_addr;
   logic [LW:0]   mem_rd_data;
   logic          mem_wr_en;
   logic [7:0]    mem_wr_addr;
   logic [LW:0]   mem_wr_data;
   logic          err;
   logic [3:0]    tap_idx;
   logic [4:0]    pad_count;

   modport master (
      input  Start, mem_rd_data,
      output Ack, mem_addr, mem_wr_en, mem_wr_addr, mem_wr_data, err, tap_idx, pad_count
   );

   modport slave (
      output Start, mem_rd_data,
      input  Ack, mem_addr, mem_wr_en, mem_wr_addr, mem_wr_data, err, tap_idx, pad_count
   );
endinterface

// File: rtl/lfsr_depad_engine.sv
// LFSR message cracker: finds seed/tap from known pad bytes, decrypts, strips leading pad, writes plaintext.
// Latency: 1 + sum(1 + checked bytes per tried tap) + (pad_count + 1) + MSG_LEN cycles from first Start-low cycle to Ack.
// No backpressure: one memory access per cycle; Start is ignored while a run is in progress.
module lfsr_depad_engine #(
   parameter int         LW        = 7,
   parameter int         MSG_LEN   = 64,
   parameter int         NUM_TAPS  = 9,
   parameter int         CHECK_LEN = 8,
   parameter int         MAX_SKIP  = 26,
   parameter int         SRC_BASE  = 64,
   parameter int         DST_BASE  = 0,
   parameter int         TAP_BASE  = 128,
   parameter logic [7:0] PAD_CHAR  = 8'h20
) (
   input  logic                  Clk,
   input  logic                  Reset,
   lfsr_depad_engine_if.master   bus
);

   localparam int JW = $clog2(CHECK_LEN + 1);

   // The seed capture happens in the armed IDLE cycle itself, so the source
   // read of byte 0 lines up with the first Start-low cycle.
   typedef enum logic [2:0] {
      S_IDLE,
      S_TAPRD,
      S_CHECK,
      S_SKIP,
      S_WRITE,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic            armed_q, armed_d;
   logic [LW-1:0]   seed_q, seed_d;
   logic [LW-1:0]   tap_q, tap_d;
   logic [LW-1:0]   s_q, s_d;
   logic [3:0]      k_q, k_d;
   logic [JW-1:0]   j_q, j_d;
   logic [7:0]      i_q, i_d;
   logic [7:0]      n_q, n_d;
   logic            ack_q, ack_d;
   logic            err_q, err_d;
   logic [3:0]      tap_idx_q, tap_idx_d;
   logic [4:0]      pad_count_q, pad_count_d;

   logic [7:0]      mem_addr;
   logic [7:0]      mem_wr_addr;
   logic            mem_wr_en;
   logic [LW:0]     mem_wr_data;
   logic [LW:0]     rd_byte;
   logic [LW-1:0]   c_plain;
   logic            c_perr;
   logic            is_pad;
   logic [LW-1:0]   pad_lw;

   function automatic logic [LW-1:0] lfsr_step(input logic [LW-1:0] s, input logic [LW-1:0] t);
      return {s[LW-2:0], ^(s & t)};
   endfunction

   // Next-state, datapath and memory-port decode for the current access.
   always_comb begin
      state_d     = state_q;
      armed_d     = armed_q;
      seed_d      = seed_q;
      tap_d       = tap_q;
      s_d         = s_q;
      k_d         = k_q;
      j_d         = j_q;
      i_d         = i_q;
      n_d         = n_q;
      ack_d       = ack_q;
      err_d       = err_q;
      tap_idx_d   = tap_idx_q;
      pad_count_d = pad_count_q;
      mem_addr    = 8'(SRC_BASE);
      mem_wr_addr = 8'(DST_BASE);
      mem_wr_en   = 1'b0;
      mem_wr_data = '0;
      pad_lw      = PAD_CHAR[LW-1:0];
      rd_byte     = bus.mem_rd_data;
      c_plain     = rd_byte[LW-1:0] ^ s_q;
      c_perr      = rd_byte[LW] ^ (^rd_byte[LW-1:0]);
      is_pad      = !c_perr && (c_plain == pad_lw);

      case (state_q)
         S_IDLE: begin
            if (bus.Start) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               armed_d     = 1'b0;
               seed_d      = rd_byte[LW-1:0] ^ pad_lw;
               k_d         = '0;
               err_d       = 1'b0;
               tap_idx_d   = '0;
               pad_count_d = '0;
               state_d     = S_TAPRD;
            end
         end
         S_TAPRD: begin
            mem_addr = 8'(TAP_BASE) + 8'(k_q);
            tap_d    = rd_byte[LW-1:0];
            s_d      = lfsr_step(seed_q, rd_byte[LW-1:0]);
            j_d      = JW'(1);
            state_d  = S_CHECK;
         end
         S_CHECK: begin
            mem_addr = 8'(SRC_BASE) + 8'(j_q);
            if (!is_pad) begin
               if (k_q == 4'(NUM_TAPS - 1)) begin
                  err_d   = 1'b1;
                  ack_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  k_d     = k_q + 4'd1;
                  state_d = S_TAPRD;
               end
            end else if (j_q == JW'(CHECK_LEN)) begin
               tap_idx_d = k_q;
               s_d       = seed_q;
               i_d       = '0;
               state_d   = S_SKIP;
            end else begin
               j_d = j_q + JW'(1);
               s_d = lfsr_step(s_q, tap_q);
            end
         end
         S_SKIP: begin
            mem_addr = 8'(SRC_BASE) + i_q;
            if (is_pad && (i_q < 8'(MAX_SKIP - 1))) begin
               i_d = i_q + 8'd1;
               s_d = lfsr_step(s_q, tap_q);
            end else begin
               if (is_pad) begin
                  // Skip limit hit on a pad byte: it is consumed, keep s aligned with i.
                  pad_count_d = 5'(MAX_SKIP);
                  i_d         = 8'(MAX_SKIP);
                  s_d         = lfsr_step(s_q, tap_q);
               end else begin
                  pad_count_d = 5'(i_q);
               end
               n_d     = '0;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            // Reset gates the strobe so an aborting edge never commits a write.
            mem_wr_en   = !Reset;
            mem_wr_addr = 8'(DST_BASE) + n_q;
            mem_addr    = 8'(SRC_BASE) + i_q;
            if (i_q < 8'(MSG_LEN)) begin
               mem_wr_data = {c_perr, c_plain};
               i_d         = i_q + 8'd1;
               s_d         = lfsr_step(s_q, tap_q);
            end else begin
               mem_wr_data = {1'b0, pad_lw};
            end
            if (n_q == 8'(MSG_LEN - 1)) begin
               ack_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               n_d = n_q + 8'd1;
            end
         end
         S_DONE: begin
            if (bus.Start) begin
               ack_d   = 1'b0;
               armed_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and status registers; synchronous reset aborts any run in progress.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         armed_q     <= 1'b0;
         seed_q      <= '0;
         tap_q       <= '0;
         s_q         <= '0;
         k_q         <= '0;
         j_q         <= '0;
         i_q         <= '0;
         n_q         <= '0;
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
         tap_idx_q   <= '0;
         pad_count_q <= '0;
      end else begin
         state_q     <= state_d;
         armed_q     <= armed_d;
         seed_q      <= seed_d;
         tap_q       <= tap_d;
         s_q         <= s_d;
         k_q         <= k_d;
         j_q         <= j_d;
         i_q         <= i_d;
         n_q         <= n_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         tap_idx_q   <= tap_idx_d;
         pad_count_q <= pad_count_d;
      end
   end

   assign bus.Ack         = ack_q;
   assign bus.err         = err_q;
   assign bus.tap_idx     = tap_idx_q;
   assign bus.pad_count   = pad_count_q;
   assign bus.mem_addr    = mem_addr;
   assign bus.mem_wr_addr = mem_wr_addr;
   assign bus.mem_wr_en   = mem_wr_en;
   assign bus.mem_wr_data = mem_wr_data;

endmodule

// File: tb/tb_lfsr_depad_engine.sv
// Directed bench for lfsr_depad_engine: builds encrypted memory images and checks decrypted output.
module tb_lfsr_depad_engine;
   localparam int LW   = 7;
   localparam int SRC  = 64;
   localparam int DST  = 0;
   localparam int TAPB = 128;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lfsr_depad_engine_if #(.LW(LW)) bus ();
   lfsr_depad_engine #(.LW(LW)) dut (.Clk(clk), .Reset(rst), .bus(bus));

   logic [7:0] mem [256];
   int         wr_count = 0;
   int         tests_run = 0;
   int         tests_failed = 0;
   logic [7:0] plain   [64];
   logic [7:0] exp_dst [64];
   logic [6:0] tap_tbl [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};

   assign bus.mem_rd_data = mem[bus.mem_addr];

   always @(posedge clk) begin
      if (bus.mem_wr_en) begin
         mem[bus.mem_wr_addr] <= bus.mem_wr_data;
         wr_count <= wr_count + 1;
      end
   end

   task build_plain();
      string msg;
      msg = "  Two  spaces  in  between  ,  2  . ";
      for (int i = 0; i < 64; i++)
         plain[i] = (i >= 12 && i < 48) ? msg[i-12] : 8'h20;
   endtask

   task load_taps(input bit zeros);
      for (int k = 0; k < 9; k++)
         mem[TAPB+k] <= zeros ? 8'h00 : {1'b0, tap_tbl[k]};
   endtask

   task load_cipher(input logic [6:0] tap, input logic [6:0] seed);
      logic [6:0] s, x;
      s = seed;
      for (int i = 0; i < 64; i++) begin
         x = plain[i][6:0] ^ s;
         mem[SRC+i] <= {^x, x};
         s = {s[5:0], ^(s & tap)};
      end
   endtask

   task fill_dst(input logic [7:0] v);
      for (int n = 0; n < 64; n++) mem[DST+n] <= v;
   endtask

   task build_exp(input int pc);
      for (int n = 0; n < 64; n++)
         exp_dst[n] = (pc + n < 64) ? plain[pc+n] : 8'h20;
   endtask

   task check_dst(input string name);
      int bad, first;
      bad = 0; first = -1;
      for (int n = 0; n < 64; n++)
         if (mem[DST+n] !== exp_dst[n]) begin
            bad++;
            if (first < 0) first = n;
         end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL %s: %0d bad bytes, first dst[%0d] got %h expected %h",
                  name, bad, first, mem[DST+first], exp_dst[first]);
      end
   endtask

   task chk(input string name, input int got, input int expv);
      tests_run++;
      if (got !== expv) begin
         tests_failed++;
         $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, got, got, expv, expv);
      end
   endtask

   // Arms with Start high for arm_cycles edges, drops Start, runs to Ack.
   task run(input int arm_cycles, input int pulse_at, output int cyc, output int start_addr, output int arm_wr);
      int w0;
      bit done;
      w0 = wr_count;
      bus.Start = 1'b1;
      repeat (arm_cycles) @(posedge clk);
      #1 arm_wr = wr_count - w0;
      bus.Start = 1'b0;
      #1 start_addr = int'(bus.mem_addr);
      cyc = 0;
      done = 1'b0;
      while (!done && cyc < 2000) begin
         @(posedge clk);
         cyc++;
         #1;
         if (pulse_at > 0 && cyc == pulse_at) bus.Start = 1'b1;
         else bus.Start = 1'b0;
         if (bus.Ack === 1'b1) done = 1'b1;
      end
      if (!done) begin
         tests_run++;
         tests_failed++;
         $display("FAIL run_timeout: no Ack after %0d cycles", cyc);
      end
   endtask

   task test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ack_wr", int'({bus.Ack, bus.mem_wr_en}), 0);
      chk("reset_status", int'({bus.err, bus.tap_idx, bus.pad_count}), 0);
      rst = 1'b0;
   endtask

   task test_nominal();
      int cyc, sa, aw, w0;
      load_taps(1'b0);
      load_cipher(7'h60, 7'h47);
      fill_dst(8'hAA);
      build_exp(14);
      @(posedge clk); #1;
      chk("nom_src0", int'(mem[SRC]), 'hE7);
      w0 = wr_count;
      run(1, 0, cyc, sa, aw);
      chk("nom_latency", cyc, 89);
      chk("nom_tap_idx", int'(bus.tap_idx), 0);
      chk("nom_pad_count", int'(bus.pad_count), 14);
      chk("nom_err", int'(bus.err), 0);
      chk("nom_writes", wr_count - w0, 64);
      chk("nom_dst0", int'(mem[DST]), 'h54);
      check_dst("nom_dst");
   endtask

   task test_last_tap();
      int cyc, sa, aw;
      load_cipher(7'h7B, 7'h47);
      fill_dst(8'hAA);
      build_exp(14);
      run(1, 0, cyc, sa, aw);
      chk("last_tap_idx", int'(bus.tap_idx), 8);
      chk("last_pad_count", int'(bus.pad_count), 14);
      chk("last_err", int'(bus.err), 0);
      check_dst("last_dst");
   endtask

   task test_corruption();
      int cyc, sa, aw;
      load_cipher(7'h60, 7'h47);
      fill_dst(8'hAA);
      #1;
      mem[SRC+40] <= mem[SRC+40] ^ 8'h04;
      mem[SRC+45] <= mem[SRC+45] ^ 8'h80;
      build_exp(14);
      exp_dst[26] = 8'h80 | (plain[40] ^ 8'h04);
      exp_dst[31] = 8'h80 | plain[45];
      run(1, 0, cyc, sa, aw);
      chk("corr_bad_payload", int'(mem[DST+26]), 'hA8);
      chk("corr_bad_parity", int'(mem[DST+31]), 'hA0);
      check_dst("corr_dst");
   endtask

   task test_no_match();
      int cyc, sa, aw, w0;
      load_taps(1'b1);
      load_cipher(7'h60, 7'h47);
      fill_dst(8'hAA);
      for (int n = 0; n < 64; n++) exp_dst[n] = 8'hAA;
      w0 = wr_count;
      run(1, 0, cyc, sa, aw);
      chk("nomatch_latency", cyc, 19);
      chk("nomatch_err", int'(bus.err), 1);
      chk("nomatch_ack", int'(bus.Ack), 1);
      chk("nomatch_writes", wr_count - w0, 0);
      check_dst("nomatch_dst");
   endtask

   task test_handshake();
      int cyc, sa, aw;
      load_taps(1'b0);
      load_cipher(7'h60, 7'h47);
      fill_dst(8'hAA);
      build_exp(14);
      run(20, 40, cyc, sa, aw);
      chk("hs_hold_writes", aw, 0);
      chk("hs_start_addr", sa, 64);
      chk("hs_latency_with_pulse", cyc, 89);
      chk("hs_tap_idx", int'(bus.tap_idx), 0);
      check_dst("hs_dst");
   endtask

   task test_reset_mid_write();
      int cyc;
      bit hit;
      load_cipher(7'h60, 7'h47);
      fill_dst(8'hAA);
      build_exp(14);
      for (int n = 10; n < 64; n++) exp_dst[n] = 8'hAA;
      bus.Start = 1'b1;
      @(posedge clk); #1;
      bus.Start = 1'b0;
      hit = 1'b0;
      cyc = 0;
      while (!hit && cyc < 200) begin
         @(posedge clk);
         cyc++;
         #1;
         if (bus.mem_wr_en === 1'b1 && bus.mem_wr_addr === 8'(DST + 10)) hit = 1'b1;
      end
      chk("rmw_reached_n10", int'(hit), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rmw_ack", int'(bus.Ack), 0);
      chk("rmw_wr_en", int'(bus.mem_wr_en), 0);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("rmw_idle_wr_en", int'(bus.mem_wr_en), 0);
      check_dst("rmw_dst");
   endtask

   initial begin
      bus.Start = 1'b0;
      build_plain();
      test_reset();
      test_nominal();
      test_last_tap();
      test_corruption();
      test_no_match();
      test_handshake();
      test_reset_mid_write();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
